// File: rtl/iob_cache_be_responder.sv
// Native-memory responder for the cache back-end interface.
//
// Accepts single-word read/write requests and executes them against an internal
// word-addressed RAM. Each request completes with a one-cycle be_ack_o pulse
// exactly ACK_LAT cycles after the cycle in which it was accepted. A request
// presented in the ack cycle is accepted immediately, so an initiator holding
// be_valid_i high gets one ack every ACK_LAT cycles.
//
// Ports:
//   clk_i       clock
//   reset_i     asynchronous, active-high reset (RAM contents are kept)
//   be_valid_i  request valid
//   be_addr_i   byte address; the low BE_NBYTES_W bits are ignored and the
//               word index aliases modulo the RAM depth
//   be_wdata_i  write data
//   be_wstrb_i  byte strobes; all zero means read
//   be_rdata_o  read data, valid in the ack cycle and held afterwards
//   be_ack_o    one-cycle completion pulse (registered)
//   rd_count_o  completed reads, saturating
//   wr_count_o  completed writes, saturating
module iob_cache_be_responder #(
  parameter int unsigned BE_ADDR_W   = 24,
  parameter int unsigned BE_DATA_W   = 32,
  parameter int unsigned BE_NBYTES   = BE_DATA_W / 8,
  parameter int unsigned BE_NBYTES_W = $clog2(BE_NBYTES),
  parameter int unsigned MEM_ADDR_W  = 8,
  parameter int unsigned ACK_LAT     = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 be_valid_i,
  input  logic [BE_ADDR_W-1:0] be_addr_i,
  input  logic [BE_DATA_W-1:0] be_wdata_i,
  input  logic [BE_NBYTES-1:0] be_wstrb_i,
  output logic [BE_DATA_W-1:0] be_rdata_o,
  output logic                 be_ack_o,
  output logic [CNT_W-1:0]     rd_count_o,
  output logic [CNT_W-1:0]     wr_count_o
);

  localparam int unsigned MemDepth = 2 ** MEM_ADDR_W;
  localparam logic [3:0]  AckLatM1 = 4'(ACK_LAT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [MEM_ADDR_W-1:0]  addr_q;
  logic [BE_DATA_W-1:0]   wdata_q;
  logic [BE_NBYTES-1:0]   wstrb_q;
  logic [BE_DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]       rd_cnt_q, wr_cnt_q;

  logic [BE_DATA_W-1:0]   mem [MemDepth];

  logic                   accept;
  logic                   go_ack;
  logic                   mem_en;
  logic [MEM_ADDR_W-1:0]  acc_idx;
  logic [BE_DATA_W-1:0]   acc_wdata;
  logic [BE_NBYTES-1:0]   acc_wstrb;
  logic                   acc_write;

  // Only the word-index bits of the address are meaningful.
  logic unused_addr_bits;
  assign unused_addr_bits = ^be_addr_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    go_ack  = 1'b0;
    unique case (state_q)
      StIdle, StAck: begin
        if (be_valid_i) begin
          accept = 1'b1;
          cnt_d  = AckLatM1;
          if (ACK_LAT == 1) begin
            state_d = StAck;
            go_ack  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StAck;
          go_ack  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // With ACK_LAT=1 the RAM is accessed in the accepting cycle itself, before the
  // request registers are loaded, so the access takes the live inputs then.
  always_comb begin
    if (accept) begin
      acc_idx   = be_addr_i[BE_NBYTES_W +: MEM_ADDR_W];
      acc_wdata = be_wdata_i;
      acc_wstrb = be_wstrb_i;
    end else begin
      acc_idx   = addr_q;
      acc_wdata = wdata_q;
      acc_wstrb = wstrb_q;
    end
    acc_write = |acc_wstrb;
    // Keep a live input request from touching the RAM while reset is held.
    mem_en    = go_ack & ~reset_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= be_addr_i[BE_NBYTES_W +: MEM_ADDR_W];
        wdata_q <= be_wdata_i;
        wstrb_q <= be_wstrb_i;
      end
      if (mem_en && !acc_write) begin
        rdata_q <= mem[acc_idx];
      end
      // wstrb_q still describes the request being acked in this cycle.
      if (state_q == StAck) begin
        if (|wstrb_q) begin
          if (wr_cnt_q != {CNT_W{1'b1}}) wr_cnt_q <= wr_cnt_q + 1'b1;
        end else begin
          if (rd_cnt_q != {CNT_W{1'b1}}) rd_cnt_q <= rd_cnt_q + 1'b1;
        end
      end
    end
  end

  // RAM array: deliberately not reset so contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_en && acc_write) begin
      for (int i = 0; i < BE_NBYTES; i++) begin
        if (acc_wstrb[i]) mem[acc_idx][i*8 +: 8] <= acc_wdata[i*8 +: 8];
      end
    end
  end

  assign be_ack_o   = (state_q == StAck);
  assign be_rdata_o = rdata_q;
  assign rd_count_o = rd_cnt_q;
  assign wr_count_o = wr_cnt_q;

endmodule
